acc_cpu_core: RTL and testbench
===============================

// Module: acc_cpu_core
// PURPOSE
//  Parametrised accumulator CPU core; successor to the 16-bit step CPU. Fetches instruction and operand words
//  through a start/busy memory port (drives spi_ram_controller). Adds SUB/AND/STORE/JMP/JZ/HALT and a zero flag.
//  Sits between the top-level step/status pins and the SPI RAM controller.
// PARAMETERS
//  DATA_W  16  accumulator/instruction/memory word width (>=8); arithmetic modulo 2^DATA_W
//  ADDR_W  16  word address width; pc wraps modulo 2^ADDR_W
//  OUT_W   8   width of data_out; OUT executes data_out <= acc[OUT_W-1:0]
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  step       in   1       level; sampled in ST_IDLE, starts one instruction
//  run        in   1       free-run request (used only with CPU_FREE_RUN_EN)
//  busy       out  1       high in every state except IDLE/HALT/TRAP
//  halt       out  1       high in ST_HALT
//  trap       out  1       high in ST_TRAP
//  zero       out  1       acc == 0, registered with acc
//  data_out   out  OUT_W   output register
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  DATA_W  store data
//  mem_rd     out  1       one-cycle read start pulse
//  mem_wr     out  1       one-cycle write start pulse
//  mem_rdata  in   DATA_W  read data, valid when mem_busy low after request
//  mem_busy   in   1       controller busy; must rise the cycle after a start pulse
// BEHAVIOUR
//  Reset (all regs): pc=0, acc=0, inst=0, data_out=0, zero=1, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, state=IDLE.
//   Reset dominates everything, incl. mid-transaction; core does not wait for mem_busy to fall.
//  Encoding: op=inst[DATA_W-1:DATA_W-4], m=inst[DATA_W-5] (0 imm, 1 ram). Operand word X at pc+1 where used.
//   0 NOP pc+=1 | 1 LOAD acc<=V | 2 ADD acc+=V | 3 SUB acc-=V | 4 AND acc&=V | 5 STORE mem[X]<=acc (m ignored)
//   6 JMP pc<=X | 7 JZ pc<=zero?X:pc+2 | 8 OUT pc+=1 | F HALT | 9..E TRAP (pc unchanged)
//   V = X if m=0, mem[X] if m=1. LOAD/ADD/SUB/AND/STORE: pc+=2. Carry/borrow discarded; pc wraps 2^ADDR_W-1 -> 0.
//  States and transitions (mem_rd/mem_wr asserted only in *_REQ states, exactly one cycle):
//   IDLE: step=1 -> FETCH_REQ
//   FETCH_REQ: mem_addr=pc, mem_rd=1 -> FETCH_WAIT
//   FETCH_WAIT: mem_busy=0 -> inst<=mem_rdata, EXEC
//   EXEC: NOP/OUT/HALT/TRAP resolve here (-> IDLE/HALT/TRAP); else -> OPER_REQ
//   OPER_REQ: mem_addr=pc+1, mem_rd=1 -> OPER_WAIT
//   OPER_WAIT: mem_busy=0 -> latch X; imm ALU/JMP/JZ -> IDLE; m=1 ALU -> DATA_REQ; STORE -> STORE_REQ
//   DATA_REQ: mem_addr=X, mem_rd=1 -> DATA_WAIT; DATA_WAIT: mem_busy=0 -> ALU with mem_rdata -> IDLE
//   STORE_REQ: mem_addr=X, mem_wdata=acc, mem_wr=1 -> STORE_WAIT; mem_busy=0 -> IDLE
//   HALT, TRAP: absorbing until rst; step ignored.
//  WAIT states ignore mem_busy on their first cycle? No: controller guarantees busy high that cycle, so sample directly.
//  acc, zero, pc update in the same edge that leaves the final state; zero = (new acc == 0).
//  step held high re-triggers each time IDLE is reached (one instruction per IDLE visit).
//  Latency with 1-cycle memory (busy low 2nd wait cycle): NOP/OUT 4 clk, imm ALU/JMP 7, ram ALU/STORE 10.
// CONFIGURATION
//  CPU_FREE_RUN_EN defined: in IDLE, (step | run) starts next instruction; run=1 executes back-to-back
//   until HALT/TRAP or run=0 (instruction in flight always completes).
//  Undefined: run input ignored; only step starts an instruction (single-step behaviour).
// TESTING
//  1 rst=1 two cycles mid FETCH_WAIT -> all outputs reset values, state IDLE, no further mem_rd.
//  2 mem{0:LOAD#,1:0x1234,2:ADD#,3:0xFFFF,4:OUT}, 3 steps -> acc=0x1233, data_out=0x33, pc=5.
//  3 mem{0:LOAD#,1:5,2:SUB@,3:0x20,4:JZ,5:0x40}, mem[0x20]=5 -> acc=0, zero=1, pc=0x40.
//  4 LOAD# 0xBEEF, STORE 0x30 -> one mem_wr pulse, mem_addr=0x30, mem_wdata=0xBEEF; pc=4.
//  5 inst 0x9000 -> trap=1, busy=0, pc unchanged; inst 0xF000 -> halt=1; step ignored after.
//  6 CPU_FREE_RUN_EN, run=1, program ending in HALT -> no step needed, halt=1; pc=0xFFFF NOP -> pc=0.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU that fetches instruction and
// operand words through a start/busy memory port.
// Optional build macro: CPU_FREE_RUN_EN (run input starts instructions
// back-to-back from IDLE). Without it only step starts an instruction.
// Debug outputs dbg_state/dbg_pc/dbg_acc expose the FSM state and registers.
// Memory handshake: mem_rd/mem_wr are single-cycle start pulses issued only in
// the *_REQ states; the controller raises mem_busy the following cycle, and
// read data / write completion are taken on the first WAIT cycle with
// mem_busy low.
module acc_cpu_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              run,
    output logic              busy,
    output logic              halt,
    output logic              trap,
    output logic              zero,
    output logic [OUT_W-1:0]  data_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic [3:0]        dbg_state,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_acc
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_EXEC       = 4'd3,
        ST_OPER_REQ   = 4'd4,
        ST_OPER_WAIT  = 4'd5,
        ST_DATA_REQ   = 4'd6,
        ST_DATA_WAIT  = 4'd7,
        ST_STORE_REQ  = 4'd8,
        ST_STORE_WAIT = 4'd9,
        ST_HALT       = 4'd10,
        ST_TRAP       = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_OUT   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   inst_q;
    logic [OUT_W-1:0]    data_out_q;
    logic                zero_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_rd_q;
    logic                mem_wr_q;

    logic [3:0]          op;
    logic                m_ram;
    logic [DATA_W-1:0]   alu_d;
    logic [ADDR_W-1:0]   x_addr;
    logic                start;
    logic                unused_ok;

    assign op     = inst_q[DATA_W-1 -: 4];
    assign m_ram  = inst_q[DATA_W-5];
    assign x_addr = ADDR_W'(mem_rdata);

`ifdef CPU_FREE_RUN_EN
    assign start     = step | run;
    assign unused_ok = ^inst_q[DATA_W-6:0];
`else
    assign start     = step;
    assign unused_ok = ^{inst_q[DATA_W-6:0], run};
`endif

    // ALU result with V taken from the current read data (immediate or RAM word)
    always_comb begin
        alu_d = acc_q;
        case (op)
            OP_LOAD: alu_d = mem_rdata;
            OP_ADD:  alu_d = acc_q + mem_rdata;
            OP_SUB:  alu_d = acc_q - mem_rdata;
            OP_AND:  alu_d = acc_q & mem_rdata;
            default: alu_d = acc_q;
        endcase
    end

    // Instruction sequencer: fetch, decode, operand/data/store phases
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            inst_q      <= '0;
            data_out_q  <= '0;
            zero_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr_q <= pc_q;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ST_FETCH_REQ;
                    end
                end
                ST_FETCH_REQ: state_q <= ST_FETCH_WAIT;
                ST_FETCH_WAIT: begin
                    if (!mem_busy) begin
                        inst_q  <= mem_rdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_NOP: begin
                            pc_q    <= pc_q + ADDR_W'(1);
                            state_q <= ST_IDLE;
                        end
                        OP_OUT: begin
                            data_out_q <= acc_q[OUT_W-1:0];
                            pc_q       <= pc_q + ADDR_W'(1);
                            state_q    <= ST_IDLE;
                        end
                        OP_HALT: state_q <= ST_HALT;
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_STORE, OP_JMP, OP_JZ: begin
                            mem_addr_q <= pc_q + ADDR_W'(1);
                            mem_rd_q   <= 1'b1;
                            state_q    <= ST_OPER_REQ;
                        end
                        default: state_q <= ST_TRAP;
                    endcase
                end
                ST_OPER_REQ: state_q <= ST_OPER_WAIT;
                ST_OPER_WAIT: begin
                    if (!mem_busy) begin
                        case (op)
                            OP_JMP: begin
                                pc_q    <= x_addr;
                                state_q <= ST_IDLE;
                            end
                            OP_JZ: begin
                                pc_q    <= zero_q ? x_addr : pc_q + ADDR_W'(2);
                                state_q <= ST_IDLE;
                            end
                            OP_STORE: begin
                                mem_addr_q  <= x_addr;
                                mem_wdata_q <= acc_q;
                                mem_wr_q    <= 1'b1;
                                state_q     <= ST_STORE_REQ;
                            end
                            default: begin
                                if (m_ram) begin
                                    mem_addr_q <= x_addr;
                                    mem_rd_q   <= 1'b1;
                                    state_q    <= ST_DATA_REQ;
                                end else begin
                                    acc_q   <= alu_d;
                                    zero_q  <= (alu_d == '0);
                                    pc_q    <= pc_q + ADDR_W'(2);
                                    state_q <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
                ST_DATA_REQ: state_q <= ST_DATA_WAIT;
                ST_DATA_WAIT: begin
                    if (!mem_busy) begin
                        acc_q   <= alu_d;
                        zero_q  <= (alu_d == '0);
                        pc_q    <= pc_q + ADDR_W'(2);
                        state_q <= ST_IDLE;
                    end
                end
                ST_STORE_REQ: state_q <= ST_STORE_WAIT;
                ST_STORE_WAIT: begin
                    if (!mem_busy) begin
                        pc_q    <= pc_q + ADDR_W'(2);
                        state_q <= ST_IDLE;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_TRAP);
    assign halt      = (state_q == ST_HALT);
    assign trap      = (state_q == ST_TRAP);
    assign zero      = zero_q;
    assign data_out  = data_out_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign dbg_state = state_q;
    assign dbg_pc    = pc_q;
    assign dbg_acc   = acc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus randomised programs checked
// against an instruction-level reference model with its own memory image.
module tb_acc_cpu_core;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          step;
    logic          run;
    logic          busy, halt, trap, zero;
    logic [OW-1:0] data_out;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_busy  = 1'b0;
    logic [3:0]    dbg_state;
    logic [AW-1:0] dbg_pc;
    logic [DW-1:0] dbg_acc;

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .step(step), .run(run),
        .busy(busy), .halt(halt), .trap(trap), .zero(zero),
        .data_out(data_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .dbg_state(dbg_state), .dbg_pc(dbg_pc), .dbg_acc(dbg_acc)
    );

    // clock / reset
    always #5 clk = ~clk;

    // program image (written by stimulus only) and DUT-side write overlay
    logic [DW-1:0] prog [0:65535];
    logic [DW-1:0] wmem [int];
    int            extra_max = 0;

    // responder state and pulse monitors
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_wr;
    int            cnt;
    int            rd_pulses = 0;
    int            wr_pulses = 0;
    int            double_pulses = 0;
    logic          prev_rd = 1'b0, prev_wr = 1'b0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    function automatic logic [DW-1:0] dut_mem(input logic [AW-1:0] a);
        return wmem.exists(int'(a)) ? wmem[int'(a)] : prog[a];
    endfunction

    // memory controller model: busy the cycle after a start pulse, done after 0..extra_max extra cycles
    always @(posedge clk) begin
        if (mem_rd) rd_pulses++;
        if (mem_wr) begin
            wr_pulses++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if ((mem_rd && prev_rd) || (mem_wr && prev_wr)) double_pulses++;
        prev_rd = mem_rd;
        prev_wr = mem_wr;
        if (rst) begin
            mem_busy <= 1'b0;
            cnt      <= 0;
            wmem.delete();
        end else if (mem_rd || mem_wr) begin
            mem_busy <= 1'b1;
            req_addr <= mem_addr;
            req_wr   <= mem_wr;
            req_data <= mem_wdata;
            cnt      <= $urandom_range(extra_max, 0);
        end else if (mem_busy) begin
            if (cnt == 0) begin
                mem_busy <= 1'b0;
                if (req_wr) wmem[int'(req_addr)] = req_data;
                else mem_rdata <= dut_mem(req_addr);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // reference model: one whole instruction at a time
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_zero, m_halt, m_trap;
    logic [OW-1:0] m_out;
    logic [DW-1:0] m_wmem [int];
    logic [AW-1:0] exp_q [$];

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        return m_wmem.exists(int'(a)) ? m_wmem[int'(a)] : prog[a];
    endfunction

    task automatic model_reset();
        m_pc = '0; m_acc = '0; m_zero = 1'b1; m_out = '0; m_halt = 1'b0; m_trap = 1'b0;
        m_wmem.delete();
    endtask

    task automatic model_exec(output int lat);
        logic [DW-1:0] inst, x, v;
        int op;
        inst = m_rd(m_pc);
        op   = int'(inst[15:12]);
        x    = m_rd(m_pc + 16'd1);
        v    = inst[11] ? m_rd(x) : x;
        lat  = 4;
        if (m_halt || m_trap) begin
            lat = 0;
        end else if (op == 0) begin
            m_pc = m_pc + 16'd1;
        end else if (op >= 1 && op <= 4) begin
            if (op == 1) m_acc = v;
            if (op == 2) m_acc = m_acc + v;
            if (op == 3) m_acc = m_acc - v;
            if (op == 4) m_acc = m_acc & v;
            m_pc = m_pc + 16'd2;
            lat  = inst[11] ? 10 : 7;
        end else if (op == 5) begin
            m_wmem[int'(x)] = m_acc;
            m_pc = m_pc + 16'd2;
            lat  = 10;
        end else if (op == 6) begin
            m_pc = x;
            lat  = 7;
        end else if (op == 7) begin
            m_pc = m_zero ? x : m_pc + 16'd2;
            lat  = 7;
        end else if (op == 8) begin
            m_out = m_acc[7:0];
            m_pc  = m_pc + 16'd1;
        end else if (op == 15) begin
            m_halt = 1'b1;
        end else begin
            m_trap = 1'b1;
        end
        m_zero = (m_acc == 16'd0);
    endtask

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic check_model(input string tag);
        exp_q.push_back(m_pc);
        check({tag, "_pc"}, 32'(dbg_pc), 32'(exp_q.pop_front()));
        check({tag, "_acc"}, 32'(dbg_acc), 32'(m_acc));
        check({tag, "_zero"}, 32'(zero), 32'(m_zero));
        check({tag, "_out"}, 32'(data_out), 32'(m_out));
        check({tag, "_halt"}, 32'(halt), 32'(m_halt));
        check({tag, "_trap"}, 32'(trap), 32'(m_trap));
    endtask

    // driver tasks
    task automatic clear_prog();
        for (int i = 0; i < 65536; i++) prog[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; step = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_step(output int cyc);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cyc  = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("step_done", 32'(busy), 32'd0);
    endtask

    task automatic run_step(input string tag, input bit chk_lat);
        int cyc, lat;
        do_step(cyc);
        model_exec(lat);
        check_model(tag);
        if (chk_lat) check({tag, "_latency"}, 32'(cyc), 32'(lat));
    endtask

    initial begin
        int rd0, wr0, budget;
        logic [3:0] op;
        int pos, mism;
        rst = 1'b1; step = 1'b0; run = 1'b0;
        clear_prog();
        model_reset();
        do_reset();

        // reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_zero", 32'(zero), 1);
        check("rst_state", 32'(dbg_state), 0);

        // reset while a fetch is outstanding
        @(negedge clk);
        step = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_state", 32'(dbg_state), 2);
        rst = 1'b1; step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_halt_trap", 32'({halt, trap}), 0);
        check("mid_rst_zero", 32'(zero), 1);
        check("mid_rst_out", 32'(data_out), 0);
        check("mid_rst_mem", 32'({mem_rd, mem_wr}), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_wdata", 32'(mem_wdata), 0);
        check("mid_rst_pc", 32'(dbg_pc), 0);
        check("mid_rst_acc", 32'(dbg_acc), 0);
        check("mid_rst_state", 32'(dbg_state), 0);
        rd0 = rd_pulses;
        repeat (10) @(negedge clk);
        check("mid_rst_no_rd", 32'(rd_pulses - rd0), 0);

        // LOAD#, ADD# with wrap, OUT
        clear_prog();
        prog[0] = 16'h1000; prog[1] = 16'h1234; prog[2] = 16'h2000; prog[3] = 16'hFFFF; prog[4] = 16'h8000;
        do_reset();
        for (int i = 0; i < 3; i++) run_step("t2", 1'b1);
        check("t2_acc_const", 32'(dbg_acc), 32'h1233);
        check("t2_out_const", 32'(data_out), 32'h33);
        check("t2_pc_const", 32'(dbg_pc), 32'd5);

        // LOAD#, SUB from RAM, JZ taken
        clear_prog();
        prog[0] = 16'h1000; prog[1] = 16'h0005; prog[2] = 16'h3800; prog[3] = 16'h0020;
        prog[4] = 16'h7000; prog[5] = 16'h0040; prog[16'h20] = 16'h0005;
        do_reset();
        for (int i = 0; i < 3; i++) run_step("t3", 1'b1);
        check("t3_acc_const", 32'(dbg_acc), 0);
        check("t3_zero_const", 32'(zero), 1);
        check("t3_pc_const", 32'(dbg_pc), 32'h40);

        // STORE
        clear_prog();
        prog[0] = 16'h1000; prog[1] = 16'hBEEF; prog[2] = 16'h5000; prog[3] = 16'h0030;
        do_reset();
        run_step("t4_load", 1'b1);
        wr0 = wr_pulses;
        run_step("t4_store", 1'b1);
        check("t4_wr_pulses", 32'(wr_pulses - wr0), 1);
        check("t4_wr_addr", 32'(last_wr_addr), 32'h30);
        check("t4_wr_data", 32'(last_wr_data), 32'hBEEF);
        check("t4_mem", 32'(dut_mem(16'h30)), 32'hBEEF);
        check("t4_pc_const", 32'(dbg_pc), 4);

        // TRAP and HALT are absorbing
        clear_prog();
        prog[0] = 16'h9000;
        do_reset();
        run_step("t5_trap", 1'b1);
        check("t5_trap_const", 32'({trap, busy}), 32'b10);
        rd0 = rd_pulses;
        run_step("t5_trap_again", 1'b0);
        check("t5_trap_no_rd", 32'(rd_pulses - rd0), 0);
        prog[0] = 16'hF000;
        do_reset();
        run_step("t5_halt", 1'b1);
        check("t5_halt_const", 32'({halt, busy}), 32'b10);
        rd0 = rd_pulses;
        run_step("t5_halt_again", 1'b0);
        check("t5_halt_no_rd", 32'(rd_pulses - rd0), 0);

        // pc wraps from 0xFFFF to 0
        clear_prog();
        prog[0] = 16'h6000; prog[1] = 16'hFFFF;
        do_reset();
        run_step("t6_jmp", 1'b1);
        check("t6_pc_top", 32'(dbg_pc), 32'hFFFF);
        run_step("t6_nop", 1'b1);
        check("t6_pc_wrap", 32'(dbg_pc), 0);

        // run input
        clear_prog();
        prog[0] = 16'h1000; prog[1] = 16'h0003; prog[2] = 16'h2000; prog[3] = 16'h0004;
        prog[4] = 16'h8000; prog[5] = 16'hF000;
        do_reset();
        rd0 = rd_pulses;
        @(negedge clk);
        run = 1'b1;
`ifdef CPU_FREE_RUN_EN
        budget = 0;
        while (!halt && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        check("fr_halt", 32'(halt), 1);
        check("fr_out", 32'(data_out), 32'h07);
        check("fr_pc", 32'(dbg_pc), 5);
`else
        repeat (20) @(negedge clk);
        check("run_ignored_rd", 32'(rd_pulses - rd0), 0);
        check("run_ignored_busy", 32'(busy), 0);
`endif
        run = 1'b0;

        // randomised programs with variable memory latency
        extra_max = 3;
        for (int p = 0; p < 4; p++) begin
            clear_prog();
            pos = 0;
            while (pos < 60) begin
                int pick;
                pick = int'($urandom_range(21, 0));
                op   = (pick < 18) ? 4'(pick % 9) : (pick < 20 ? 4'hF : 4'(9 + pick % 6));
                prog[pos] = {op, 1'($urandom_range(1, 0)), 11'($urandom)};
                if (op >= 4'h1 && op <= 4'h7) begin
                    if (op == 4'h6 || op == 4'h7) prog[pos + 1] = 16'($urandom_range(59, 0));
                    else if (op == 4'h5 || prog[pos][11]) prog[pos + 1] = 16'h0100 + 16'($urandom_range(15, 0));
                    else prog[pos + 1] = 16'($urandom);
                    pos += 2;
                end else begin
                    pos += 1;
                end
            end
            for (int a = 16'h100; a < 16'h110; a++) prog[a] = 16'($urandom);
            do_reset();
            for (int s = 0; s < 30 && !m_halt && !m_trap; s++) run_step("rnd", 1'b0);
            mism = 0;
            for (int a = 16'h100; a < 16'h110; a++)
                if (dut_mem(16'(a)) !== m_rd(16'(a))) mism++;
            check("rnd_mem", 32'(mism), 0);
        end

        check("single_cycle_pulses", 32'(double_pulses), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
